// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared FSM encodings and constants for the data-memory responder
package data_mem_responder_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
    localparam logic [1:0] MMIO_SEL    = 2'b11;
    localparam int         DEF_LATENCY = 2;
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request and response handshake between initiator and responder
interface data_mem_responder_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: word RAM with one synchronous write port, a response read port and a debug read port
module dmem_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    // clear every word on reset, otherwise commit one write per edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata    = mem[raddr];
    assign dbg_data = mem[dbg_addr];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder returning each load/store after LATENCY wait cycles.
// Define DATA_MEM_MMIO_EN to map the top quarter of the address space onto io_sw/io_led.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]    dbg_data,
    input  logic [3:0]           io_sw,
    output logic [7:0]           io_led
);
`ifdef DATA_MEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif
    localparam logic [3:0] LOAD_CNT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              accept, cur_we, cur_io, ram_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;

    // In IDLE the live request is used so that a zero-latency access can complete on its accept edge
    assign accept    = (state == ST_IDLE) && bus.req_valid;
    assign cur_we    = (state == ST_IDLE) ? bus.req_we    : l_we;
    assign cur_addr  = (state == ST_IDLE) ? bus.req_addr  : l_addr;
    assign cur_wdata = (state == ST_IDLE) ? bus.req_wdata : l_wdata;
    assign cur_io    = MMIO && (cur_addr[ADDR_W-1 -: 2] == MMIO_SEL);
    assign ram_we    = accept && cur_we && !cur_io;

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = rdata;

    // next-state selection for the IDLE -> WAIT -> RESP request cycle
    always_comb begin
        state_nx = ST_IDLE;
        if (state == ST_IDLE)
            state_nx = accept ? ((LATENCY == 0) ? ST_RESP : ST_WAIT) : ST_IDLE;
        else if (state == ST_WAIT)
            state_nx = (cnt == '0) ? ST_RESP : ST_WAIT;
    end

    // state, wait counter, latched request, response data and LED register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            l_we    <= 1'b0;
            l_addr  <= '0;
            l_wdata <= '0;
            rdata   <= '0;
            io_led  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= accept ? LOAD_CNT : ((state == ST_WAIT && cnt != '0) ? cnt - 4'd1 : cnt);
            if (accept) begin
                l_we    <= bus.req_we;
                l_addr  <= bus.req_addr;
                l_wdata <= bus.req_wdata;
            end
            if (accept && cur_we && cur_io) io_led <= cur_wdata[7:0];
            if (state_nx == ST_RESP)
                rdata <= cur_we ? cur_wdata : (cur_io ? DATA_W'(io_sw) : mem_rdata);
        end
    end

    dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
        .clk      (clk),
        .rst      (rst),
        .we       (ram_we),
        .waddr    (cur_addr),
        .wdata    (cur_wdata),
        .raddr    (cur_addr),
        .rdata    (mem_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );
endmodule
